// File: rtl/mersenne_fold_reduce_pkg.sv
// Shared constants and width helpers for the Mersenne fold reducer.
// The optional canonicalising stage is enabled by defining SEEK_CANON_EN.
package mersenne_fold_reduce_pkg;

   localparam int unsigned KDefault  = 13;
   localparam int unsigned Datawidth = 2 * KDefault;

   // Modulus M = 2^k - 1.
   function automatic longint unsigned modulus(input int unsigned k);
      return (64'd1 << k) - 64'd1;
   endfunction

   // Output width of one fold: the wider addend plus a carry bit.
   function automatic int unsigned fold_width(input int unsigned iw, input int unsigned k);
      return (((iw - k) > k) ? (iw - k) : k) + 1;
   endfunction

   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
      return lane * w;
   endfunction

endpackage

// File: rtl/mersenne_fold_reduce_fold.sv
// One Mersenne fold: low K bits plus the remaining high bits, full width (no truncation).
module mfr_fold
   import mersenne_fold_reduce_pkg::*;
#(
   parameter int unsigned IW = Datawidth,
   parameter int unsigned K  = KDefault
) (
   input  logic [IW-1:0]                x,
   output logic [fold_width(IW, K)-1:0] y
);

   localparam int unsigned OW = fold_width(IW, K);

   assign y = OW'(x[K-1:0]) + OW'(x[IW-1:K]);

endmodule

// File: rtl/mersenne_fold_reduce.sv
// Multi-lane x mod (2^K-1) pipeline with per-stage valid/ready; two fold stages, plus a
// third stage mapping M to 0 when SEEK_CANON_EN is defined.
module mersenne_fold_reduce
   import mersenne_fold_reduce_pkg::*;
#(
   parameter int unsigned DW    = Datawidth,
   parameter int unsigned K     = KDefault,
   parameter int unsigned LANES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES*DW-1:0]  in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*K-1:0]   out_data
);

   localparam int unsigned W1     = fold_width(DW, K);
   localparam int unsigned W2     = fold_width(W1, K);
   localparam logic [K-1:0] Mod   = K'(modulus(K));

   logic                 v1_q, v2_q;
   logic                 acc1, acc2;
   logic [LANES*W1-1:0]  s1_data_d, s1_data_q;
   logic [LANES*K-1:0]   s2_data_d, s2_data_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [W2-1:0]   f2;
      logic [W2-K-1:0] f2_hi_unused;

      mfr_fold #(.IW(DW), .K(K)) u_fold1 (
         .x (in_data[lane_lsb(i, DW) +: DW]),
         .y (s1_data_d[lane_lsb(i, W1) +: W1])
      );

      mfr_fold #(.IW(W1), .K(K)) u_fold2 (
         .x (s1_data_q[lane_lsb(i, W1) +: W1]),
         .y (f2)
      );

      // Second fold never exceeds M, so its upper bits are always zero.
      assign s2_data_d[lane_lsb(i, K) +: K] = f2[K-1:0];
      assign f2_hi_unused                   = f2[W2-1:K];
   end

   assign acc1     = !v1_q || acc2;
   assign in_ready = acc1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         s1_data_q <= '0;
         s2_data_q <= '0;
      end else begin
         if (acc1) begin
            v1_q <= in_valid;
            if (in_valid) s1_data_q <= s1_data_d;
         end
         if (acc2) begin
            v2_q <= v1_q;
            if (v1_q) s2_data_q <= s2_data_d;
         end
      end
   end

`ifdef SEEK_CANON_EN
   logic                v3_q;
   logic                acc3;
   logic [LANES*K-1:0]  s3_data_d, s3_data_q;

   for (genvar i = 0; i < LANES; i++) begin : g_canon
      assign s3_data_d[lane_lsb(i, K) +: K] =
         (s2_data_q[lane_lsb(i, K) +: K] == Mod) ? '0 : s2_data_q[lane_lsb(i, K) +: K];
   end

   assign acc3      = !v3_q || out_ready;
   assign acc2      = !v2_q || acc3;
   assign out_valid = v3_q;
   assign out_data  = s3_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3_q      <= 1'b0;
         s3_data_q <= '0;
      end else if (acc3) begin
         v3_q <= v2_q;
         if (v2_q) s3_data_q <= s3_data_d;
      end
   end
`else
   logic [K-1:0] mod_unused;

   assign mod_unused = Mod;
   assign acc2       = !v2_q || out_ready;
   assign out_valid  = v2_q;
   assign out_data   = s2_data_q;
`endif

endmodule

// File: tb/tb_mersenne_fold_reduce.sv
// Self-checking bench for mersenne_fold_reduce (4 lanes, K=13, DW=26) against x mod 8191.
module tb_mersenne_fold_reduce;

   localparam int unsigned DW    = 26;
   localparam int unsigned K     = 13;
   localparam int unsigned LANES = 4;
`ifdef SEEK_CANON_EN
   localparam bit Canon = 1'b1;
`else
   localparam bit Canon = 1'b0;
`endif
   localparam int unsigned Lat    = Canon ? 3 : 2;
   localparam int unsigned ZeroM  = Canon ? 0 : 8191;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [LANES*DW-1:0] in_data;
   logic                out_valid;
   logic                out_ready;
   logic [LANES*K-1:0]  out_data;

   int checks   = 0;
   int failures = 0;
   int n_out    = 0;

   logic [LANES*K-1:0] exp_q[$];
   logic               stall_q = 1'b0;
   logic [LANES*K-1:0] held;

   mersenne_fold_reduce #(.DW(DW), .K(K), .LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: true residue, except a nonzero multiple of M reads back as M when not canonical.
   function automatic logic [K-1:0] ref_mod(input logic [DW-1:0] x);
      longint unsigned r;
      r = longint'(x) % 8191;
      if (!Canon && r == 0 && x != 0) r = 8191;
      return r[K-1:0];
   endfunction

   function automatic logic [LANES*K-1:0] ref_vec(input logic [LANES*DW-1:0] v);
      logic [LANES*K-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*K +: K] = ref_mod(v[i*DW +: DW]);
      return r;
   endfunction

   function automatic logic [LANES*DW-1:0] rand_vec();
      logic [LANES*DW-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   // Scoreboard: inputs pushed, outputs popped in order, stalled output must hold.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_hold", out_data, held);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("spurious_out", out_valid, 0);
            else check_eq("out_data", out_data, exp_q.pop_front());
            n_out++;
         end
         stall_q = out_valid && !out_ready;
         held    = out_data;
         if (in_valid && in_ready) exp_q.push_back(ref_vec(in_data));
      end
   end

   // Sends one vector into an empty pipeline (out_ready high) and returns edges to out_valid.
   task automatic send_one(input logic [LANES*DW-1:0] v, output int lat);
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_lanes(input string tag, input logic [4*K-1:0] exp);
      for (int i = 0; i < LANES; i++)
         check_eq($sformatf("%s_lane%0d", tag, i), out_data[i*K +: K], exp[i*K +: K]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int lat;
      int hits;
      int base;
      logic ok;
      logic [LANES*DW-1:0] v;

      // Reset with in_valid high.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = rand_vec();
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_data", out_data, 0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check_eq("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Directed values: lanes {12345678, 8191, 8192, 2^26-1}.
      v = {26'h3FFFFFF, 26'd8192, 26'd8191, 26'd12345678};
      send_one(v, lat);
      check_eq("latency_a", lat, Lat);
      check_lanes("dir_a", {13'(ZeroM), 13'd1, 13'(ZeroM), 13'd1841});
      repeat (4) @(posedge clk);
      #1;

      // Directed values: lanes {0, 8191, 8192, 12345678}.
      v = {26'd12345678, 26'd8192, 26'd8191, 26'd0};
      send_one(v, lat);
      check_eq("latency_b", lat, Lat);
      check_lanes("dir_b", {13'd1841, 13'd1, 13'(ZeroM), 13'd0});
      repeat (4) @(posedge clk);
      #1;

      // Full throughput with out_ready held high.
      base = n_out;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = rand_vec();
         @(negedge clk);
         check_eq("tput_ready", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (Lat + 1) @(posedge clk);
      #1;
      check_eq("tput_count", n_out - base, 8);

      // Random backpressure: 10 operands, out_ready toggled pseudo-randomly.
      base = n_out;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               int tries;
               in_valid = 1'b1;
               in_data  = rand_vec();
               tries    = 0;
               ok       = 1'b0;
               while (!ok && tries < 200) begin
                  @(negedge clk);
                  ok = in_ready;
                  @(posedge clk); #1;
                  tries++;
               end
               if (!ok) check_eq("bp_accept", ok, 1);
               in_valid = 1'b0;
               if ($urandom_range(0, 2) == 0) begin
                  @(posedge clk); #1;
               end
            end
         end
         begin
            int cyc;
            cyc = 0;
            while (n_out - base < 10 && cyc < 2000) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
               cyc++;
            end
         end
      join
      out_ready = 1'b1;
      check_eq("bp_count", n_out - base, 10);
      check_eq("bp_queue_empty", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;

      // Reset with two results in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = rand_vec();
      @(posedge clk); #1;
      in_data   = rand_vec();
      @(posedge clk); #1;
      in_valid  = 1'b0;
      @(posedge clk); #3;
      check_eq("inflight_valid", out_valid, 1);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      #1;
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_out_data", out_data, 0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check_eq("midrst_in_ready", in_ready, 1);
      hits = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) hits++;
      end
      check_eq("midrst_no_ghost", hits, 0);
      @(posedge clk); #1;

      // Recovery after reset.
      v = {26'd8192, 26'd12345678, 26'd0, 26'h3FFFFFF};
      send_one(v, lat);
      check_eq("latency_c", lat, Lat);
      check_lanes("dir_c", {13'd1, 13'd1841, 13'd0, 13'(ZeroM)});
      repeat (4) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mersenne_fold_reduce.md
MERSENNE_FOLD_REDUCE -- requirements
Module: mersenne_fold_reduce

Interface
REQ-001 The block SHALL have parameter DW, default 26, meaning input operand width per lane (legal range K+1..2*K).
REQ-002 The block SHALL have parameter K, default 13, meaning modulus exponent; the modulus is M = 2^K - 1.
REQ-003 The block SHALL have parameter LANES, default 1, meaning the number of independent lanes sharing one handshake.
REQ-004 Port clk, input, 1, is the single clock; all state is on its rising edge.
REQ-005 Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-006 Port in_valid, input, 1, means the input operands are valid.
REQ-007 Port in_ready, output, 1, means the block accepts an input this cycle.
REQ-008 Port in_data, input, LANES*DW, carries the operands; lane i occupies bits [i*DW +: DW].
REQ-009 Port out_valid, output, 1, means the result is valid.
REQ-010 Port out_ready, input, 1, means the consumer accepts the result.
REQ-011 Port out_data, output, LANES*K, carries the results; lane i occupies bits [i*K +: K].

Function
REQ-012 Each lane SHALL compute x mod M by Mersenne folding: fold(x) = x[K-1:0] + (x >> K), with widths grown by one bit per add (no truncation).
REQ-013 Stage 1 SHALL register fold(in_data lane); stage 2 SHALL register fold(stage1)[K-1:0], which is provably in 0..M.
REQ-014 Transfers SHALL occur on valid&&ready at every boundary; every stage holds its own valid bit.
REQ-015 Stage s SHALL accept when its valid is low or the downstream stage accepts (bubble-collapsing); in_ready is stage 1's accept term.
REQ-016 The latency from input transfer to out_valid SHALL be 2 cycles without SEEK_CANON_EN and 3 cycles with it.
REQ-017 With out_ready held high, throughput SHALL be one result per cycle.
REQ-018 While out_valid=1 and out_ready=0, out_data SHALL be held stable and no result SHALL be lost or duplicated.
REQ-019 Results SHALL leave in input order; lanes never interact.
REQ-020 When in_valid=0, stage registers SHALL hold their data; only the valid bits clear as results drain.

Reset
REQ-021 Asserting rst_n low SHALL clear all stage valid bits and data registers to 0 asynchronously; out_valid=0 and out_data=0.
REQ-022 In-flight operands SHALL be discarded on reset mid-operation; in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-023 Macro SEEK_CANON_EN SHALL, when defined, add a third registered stage that maps the value M to 0, so out_data is canonical in 0..M-1.
REQ-024 Without SEEK_CANON_EN, out_data SHALL be the stage-2 value in 0..M (M is a legal representation of zero), with latency 2.

Structure
REQ-025 The per-lane fold adder SHALL be a sub-module, mfr_fold (parameters IW and K; combinational, output width max(IW-K,K)+1).
REQ-026 The default K, derived M and the lane-slice width helpers SHALL live in the shared package/define file alongside Datawidth; the pipeline valid/ready logic SHALL stay in the top module.

Verification
REQ-027 Reset: rst_n=0 with in_valid=1 -> out_valid=0 and out_data=0; after release, in_ready=1.
REQ-028 K=13, DW=26: input 12345678 -> out_data 1841 after 2 cycles (3 with the macro).
REQ-029 Input 8191 -> 8191 without the macro and 0 with it; input 8192 -> 1; input 2^26-1 -> 8191 or 0 respectively.
REQ-030 Backpressure: stream 10 random operands with out_ready toggled pseudo-randomly -> all 10 results in order, unchanged while stalled, none dropped.
REQ-031 LANES=4 with operands {0, 8191, 8192, 12345678} -> {0, 8191|0, 1, 1841} in matching lanes.
REQ-032 Reset asserted while 2 results are in flight -> both discarded; no out_valid until new input.
